// File: rtl/case_2_mul_pkg.sv
// Shared constants and helpers for the handshaked pipelined multiplier.
// Resize works on a wide signed container; callers truncate to their own width.
package case_2_mul_pkg;

   localparam bit SAT_WRAP  = 1'b0;
   localparam bit SAT_CLAMP = 1'b1;

   // Container width for resize_sat; operand product and dout must fit below it.
   localparam int unsigned MUL_MAX_W = 128;

   function automatic int unsigned mul_prod_width(input int unsigned w0, input int unsigned w1);
      return w0 + w1 + 2;
   endfunction

   // Wrap leaves the value untouched (caller keeps the low bits); clamp limits
   // it to the signed range of dout_width bits.
   function automatic logic signed [MUL_MAX_W-1:0] resize_sat(
      input logic signed [MUL_MAX_W-1:0] product,
      input int unsigned                 dout_width,
      input bit                          mode
   );
      logic signed [MUL_MAX_W-1:0] hi;
      logic signed [MUL_MAX_W-1:0] lo;
      logic signed [MUL_MAX_W-1:0] res;
      hi  = $signed((MUL_MAX_W'(1) << (dout_width - 1)) - MUL_MAX_W'(1));
      lo  = ~hi;
      res = product;
      if (mode == SAT_CLAMP) begin
         if (product > hi) begin
            res = hi;
         end else if (product < lo) begin
            res = lo;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/case_2_mul_pipe_stage.sv
// One valid+data slice of the multiplier pipeline with bubble-collapsing ready.
module case_2_mul_pipe_stage #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         ce,
   input  logic         in_v,
   input  logic [W-1:0] in_d,
   input  logic         rdy_next,
   output logic         v,
   output logic [W-1:0] d,
   output logic         rdy
);

   logic         v_q, v_d;
   logic [W-1:0] dat_q, dat_d;

   // An empty slice accepts even when everything downstream is stalled.
   assign rdy = ~v_q | rdy_next;

   always_comb begin
      v_d   = v_q;
      dat_d = dat_q;
      if (ce && rdy) begin
         v_d = in_v;
         if (in_v) begin
            dat_d = in_d;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         v_q   <= 1'b0;
         dat_q <= '0;
      end else begin
         v_q   <= v_d;
         dat_q <= dat_d;
      end
   end

   assign v = v_q;
   assign d = dat_q;

endmodule

// File: rtl/case_2_mul_pipe_hs.sv
// Pipelined multiplier with per-operand signedness, wrap/saturate resize and
// valid/ready handshake on both sides; NUM_STAGE slices, resize ahead of the last.
module case_2_mul_pipe_hs
   import case_2_mul_pkg::*;
#(
   parameter int ID          = 1,
   parameter int NUM_STAGE   = 3,
   parameter int din0_WIDTH  = 14,
   parameter int din1_WIDTH  = 12,
   parameter int dout_WIDTH  = 26,
   parameter int din0_SIGNED = 1,
   parameter int din1_SIGNED = 1,
   parameter int SAT_MODE    = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ce,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [din0_WIDTH-1:0] din0,
   input  logic [din1_WIDTH-1:0] din1,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [dout_WIDTH-1:0] dout,
   output logic                  busy
);

   localparam int unsigned P = mul_prod_width(din0_WIDTH, din1_WIDTH);
   localparam bit RSZ_MODE = (SAT_MODE != 0) ? SAT_CLAMP : SAT_WRAP;

   logic signed [P-1:0] a_ext, b_ext, prod;
   logic [P-1:0]          stg_in [NUM_STAGE];
   logic [dout_WIDTH-1:0] resized;
   logic [NUM_STAGE:0]    vchain;
   logic [NUM_STAGE:0]    rchain;

   always_comb begin
      if (din0_SIGNED != 0) a_ext = P'($signed(din0));
      else                  a_ext = P'(din0);
      if (din1_SIGNED != 0) b_ext = P'($signed(din1));
      else                  b_ext = P'(din1);
      prod = a_ext * b_ext;
   end

   // stg_in[k] is the data entering slice k; slice N-1 sees it through resize.
   assign stg_in[0] = prod;

   always_comb begin
      resized = dout_WIDTH'(resize_sat(MUL_MAX_W'($signed(stg_in[NUM_STAGE-1])),
                                       dout_WIDTH, RSZ_MODE));
   end

   assign vchain[0]         = in_valid;
   assign rchain[NUM_STAGE] = out_ready;

   for (genvar k = 0; k < NUM_STAGE; k++) begin : g_stage
      if (k == NUM_STAGE - 1) begin : g_last
         case_2_mul_pipe_stage #(.W(dout_WIDTH)) u_stage (
            .clk      (clk),
            .reset    (reset),
            .ce       (ce),
            .in_v     (vchain[k]),
            .in_d     (resized),
            .rdy_next (rchain[k+1]),
            .v        (vchain[k+1]),
            .d        (dout),
            .rdy      (rchain[k])
         );
      end else begin : g_mid
         case_2_mul_pipe_stage #(.W(P)) u_stage (
            .clk      (clk),
            .reset    (reset),
            .ce       (ce),
            .in_v     (vchain[k]),
            .in_d     (stg_in[k]),
            .rdy_next (rchain[k+1]),
            .v        (vchain[k+1]),
            .d        (stg_in[k+1]),
            .rdy      (rchain[k])
         );
      end
   end

   assign in_ready  = ce & rchain[0];
   assign out_valid = vchain[NUM_STAGE];
   assign busy      = |vchain[NUM_STAGE:1];

endmodule

// File: tb/tb_case_2_mul_pipe_hs.sv
// Bench for case_2_mul_pipe_hs: five parameterisations share one stimulus;
// an operand FIFO plus integer arithmetic predicts every delivered result.
module tb_case_2_mul_pipe_hs;

   logic clk = 1'b0, reset = 1'b1, ce = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic [13:0] din0 = '0;
   logic [11:0] din1 = '0;

   logic rdy_d, ov_d, bz_d;  logic [25:0] dout_d;
   logic rdy_s, ov_s, bz_s;  logic [15:0] dout_s;
   logic rdy_w, ov_w, bz_w;  logic [15:0] dout_w;
   logic rdy_u, ov_u, bz_u;  logic [25:0] dout_u;
   logic rdy_uu, ov_uu, bz_uu; logic [25:0] dout_uu;

   int checks = 0, failures = 0, delivered = 0;

   typedef struct { logic [13:0] a; logic [11:0] b; } op_t;
   op_t sb[$];

   always #5 clk = ~clk;

   case_2_mul_pipe_hs u_d (
      .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_ready(rdy_d),
      .din0(din0), .din1(din1), .out_valid(ov_d), .out_ready(out_ready),
      .dout(dout_d), .busy(bz_d));

   case_2_mul_pipe_hs #(.dout_WIDTH(16), .SAT_MODE(1)) u_s (
      .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_ready(rdy_s),
      .din0(din0), .din1(din1), .out_valid(ov_s), .out_ready(out_ready),
      .dout(dout_s), .busy(bz_s));

   case_2_mul_pipe_hs #(.dout_WIDTH(16), .SAT_MODE(0)) u_w (
      .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_ready(rdy_w),
      .din0(din0), .din1(din1), .out_valid(ov_w), .out_ready(out_ready),
      .dout(dout_w), .busy(bz_w));

   case_2_mul_pipe_hs #(.din0_SIGNED(0)) u_u (
      .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_ready(rdy_u),
      .din0(din0), .din1(din1), .out_valid(ov_u), .out_ready(out_ready),
      .dout(dout_u), .busy(bz_u));

   case_2_mul_pipe_hs #(.din0_SIGNED(0), .din1_SIGNED(0)) u_uu (
      .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_ready(rdy_uu),
      .din0(din0), .din1(din1), .out_valid(ov_uu), .out_ready(out_ready),
      .dout(dout_uu), .busy(bz_uu));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Mathematical product of the operands as each config reads them, then resized.
   function automatic logic [63:0] model(input op_t op, input bit s0, input bit s1,
                                         input int dw, input bit sat);
      longint av, bv, p, hi;
      av = s0 ? longint'($signed(op.a)) : longint'(op.a);
      bv = s1 ? longint'($signed(op.b)) : longint'(op.b);
      p  = av * bv;
      hi = (longint'(1) <<< (dw - 1)) - 1;
      if (sat && p > hi) p = hi;
      if (sat && p < -hi - 1) p = -hi - 1;
      return 64'(p) & ((64'd1 << dw) - 64'd1);
   endfunction

   // Decisions are taken at the falling edge for the transfer at the next rising edge.
   always @(negedge clk) begin
      if (reset) begin
         sb.delete();
      end else begin
         chk("in_ready", rdy_d, ce && (sb.size() < 3 || out_ready));
         chk("busy", bz_d, sb.size() != 0);
         if (sb.size() == 0) begin
            chk("out_valid_empty", ov_d, 0);
         end else if (ov_d) begin
            chk("dout_D",  dout_d,  model(sb[0], 1, 1, 26, 0));
            chk("dout_S",  dout_s,  model(sb[0], 1, 1, 16, 1));
            chk("dout_W",  dout_w,  model(sb[0], 1, 1, 16, 0));
            chk("dout_U",  dout_u,  model(sb[0], 0, 1, 26, 0));
            chk("dout_UU", dout_uu, model(sb[0], 0, 0, 26, 0));
         end
         if (ce && ov_d && out_ready && sb.size() > 0) begin
            void'(sb.pop_front());
            delivered++;
         end
         if (ce && in_valid && rdy_d) sb.push_back('{a: din0, b: din1});
      end
   end

   task automatic run_one(input logic [13:0] a, input logic [11:0] b);
      int lat;
      lat = 0;
      @(posedge clk); #1;
      ce = 1'b1; out_ready = 1'b1; in_valid = 1'b1; din0 = a; din1 = b;
      @(negedge clk);
      chk("one_in_ready", rdy_d, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      while (lat < 20) begin
         @(negedge clk);
         lat++;
         if (ov_d) break;
      end
      chk("latency", lat, 3);
   endtask

   initial begin
      int nxt, d0;
      logic [25:0] frz_dout;
      logic        frz_ov, frz_bz;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", {ov_d, ov_s, ov_w, ov_u, ov_uu}, 0);
      chk("rst_busy", {bz_d, bz_s, bz_w, bz_u, bz_uu}, 0);
      chk("rst_dout_D", dout_d, 0);
      chk("rst_dout_S", dout_s, 0);
      chk("rst_in_ready_ce0", rdy_d, 0);
      ce = 1'b1;
      #1;
      chk("rst_in_ready_ce1", {rdy_d, rdy_s, rdy_w, rdy_u, rdy_uu}, 5'b11111);
      @(posedge clk); #1;
      reset = 1'b0;

      run_one(14'h2000, 12'h800);
      chk("dir_neg_neg", dout_d, 26'd16777216);
      run_one(14'd1000, 12'd100);
      chk("dir_sat_hi", dout_s, 16'h7FFF);
      chk("dir_wrap", dout_w, 16'h86A0);
      run_one(14'(-1000), 12'd100);
      chk("dir_sat_lo", dout_s, 16'h8000);
      run_one(14'd100, 12'(-3));
      chk("dir_sat_inrange", dout_s, 16'hFED4);
      run_one(14'h3FFF, 12'hFFF);
      chk("dir_a_unsigned", dout_u, 26'h3FFC001);
      chk("dir_both_unsigned", dout_uu, 26'h3FFB001);

      // Backpressure: pairs (i, i+1), consumer stalled for cycles 4..9.
      nxt = 1;
      d0  = delivered;
      for (int c = 0; c < 80 && delivered < d0 + 10; c++) begin
         @(posedge clk); #1;
         in_valid  = (nxt <= 10);
         din0      = 14'(nxt);
         din1      = 12'(nxt + 1);
         out_ready = !(c >= 4 && c <= 9);
         @(negedge clk);
         if (c == 8) chk("bp_full_in_ready", rdy_d, 0);
         if (in_valid && rdy_d) nxt++;
      end
      chk("bp_delivered", delivered - d0, 10);
      in_valid = 1'b0;

      // Random traffic with a forced 4-cycle clock-enable gap.
      for (int c = 0; c < 60; c++) begin
         @(posedge clk); #1;
         ce        = (c >= 20 && c < 24) ? 1'b0 : ($urandom_range(0, 9) != 0);
         in_valid  = ($urandom_range(0, 3) != 0);
         din0      = 14'($urandom);
         din1      = 12'($urandom);
         out_ready = ($urandom_range(0, 2) != 0);
         @(negedge clk);
         if (c == 20) begin
            frz_dout = dout_d; frz_ov = ov_d; frz_bz = bz_d;
         end
         if (c == 23) begin
            chk("ce_freeze_dout", dout_d, frz_dout);
            chk("ce_freeze_valid", {ov_d, bz_d}, {frz_ov, frz_bz});
         end
      end
      @(posedge clk); #1;
      ce = 1'b1; out_ready = 1'b1; in_valid = 1'b0;
      for (int c = 0; c < 20 && sb.size() != 0; c++) @(negedge clk);
      chk("drain_empty", sb.size(), 0);

      // Asynchronous reset with a full pipeline.
      @(posedge clk); #1;
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         in_valid = 1'b1;
         din0 = 14'(200 + k);
         din1 = 12'(7 + k);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      @(negedge clk);
      chk("full_in_ready", rdy_d, 0);
      @(posedge clk); #3;
      reset = 1'b1;
      #1;
      chk("async_rst_out_valid", ov_d, 0);
      chk("async_rst_dout", dout_d, 0);
      chk("async_rst_busy", bz_d, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("no_stale_result", ov_d, 0);
      end
      run_one(14'd123, 12'd45);
      chk("post_reset_result", dout_d, 26'd5535);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/case_2_mul_pipe_hs.md
Name: case_2_mul_pipe_hs

Overview:
- Parametrised pipelined multiplier; next generation of the per-operator multiplier cores in the synthesised datapath.
- Adds a configurable stage count, per-operand signedness and an output resize mode (wrap or saturate).
- Adds clock-enable and valid/ready handshaking on both sides, with bubble-collapsing backpressure.
- Sits between operand-producing datapath logic and a consumer that may stall.

Parameters:
- ID, 1, instance tag; no functional effect.
- NUM_STAGE, 3, pipeline depth in register stages; legal range 1..8.
- din0_WIDTH, 14, width of operand A.
- din1_WIDTH, 12, width of operand B.
- dout_WIDTH, 26, result width.
- din0_SIGNED, 1, 1 = A is two's complement, 0 = A is unsigned.
- din1_SIGNED, 1, 1 = B is two's complement, 0 = B is unsigned.
- SAT_MODE, 0, 0 = wrap (keep low dout_WIDTH bits), 1 = saturate to the signed dout_WIDTH range.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- ce  in  1  clock enable; 0 freezes all state.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block accepts the pair this cycle.
- din0  in  din0_WIDTH  operand A.
- din1  in  din1_WIDTH  operand B.
- out_valid  out  1  dout valid.
- out_ready  in  1  consumer accepts dout.
- dout  out  dout_WIDTH  resized product.
- busy  out  1  OR of all stage valid bits.

Behaviour:
- Reset (async assert, release synchronous to clk): all stage valid bits cleared and all data registers set to 0. Result: out_valid=0, dout=0, busy=0. in_ready=1 only if ce=1.
- Reset mid-operation discards every in-flight result. No output is produced for operations accepted before reset.
- Operand extension:
  - Each operand is extended by 1 bit: sign-extended if its SIGNED parameter is 1, zero-extended if 0.
  - The product is a signed multiply of the extended operands.
  - Exact product width P = din0_WIDTH + din1_WIDTH + 2.
- Resize, applied before the final stage register:
  - dout_WIDTH >= P: sign-extend the product.
  - dout_WIDTH < P, SAT_MODE=0: take product[dout_WIDTH-1:0].
  - dout_WIDTH < P, SAT_MODE=1: clamp to [-2^(dout_WIDTH-1), 2^(dout_WIDTH-1)-1].
- Stage structure: stages 1..NUM_STAGE, each with a valid bit v[k] and a data register.
  - The multiply is computed combinationally from the inputs and captured into stage 1.
  - Stages 2..N shift the data.
  - For NUM_STAGE=1, multiply and resize both sit in stage 1.
- Per-stage ready: rdy[N] = out_ready; rdy[k] = !v[k] | rdy[k+1].
- in_ready = ce & rdy[1] (combinational from out_ready; documented, no skid buffer).
- Stage k loads when ce & rdy[k]:
  - v[k] takes the previous stage's valid (in_valid for stage 1).
  - The data register loads only when the incoming valid is 1. The data register holds otherwise.
- out_valid = v[N]; dout = stage N data.
- Transfer semantics: a transfer happens on a cycle with valid & ready & ce.
- Once out_valid=1, dout stays stable until the transfer.
- Latency: exactly NUM_STAGE cycles from input acceptance to out_valid with no stall. Throughput is 1 per cycle.
- Bubbles collapse: an empty stage accepts data even while a downstream stage is stalled.
- Capacity: NUM_STAGE results in flight. After N accepts with out_ready=0, in_ready=0.
- Simultaneous output handshake and input accept while full is allowed, so a full pipeline still sustains 1 per cycle.
- ce=0: no state changes; in_ready=0; out_valid and dout hold. No transfer occurs even if out_ready=1.
- Ordering: strict FIFO; no result is dropped or duplicated under any pattern of ce or out_ready.

Decomposition:
- Shared package case_2_mul_pkg:
  - SAT_WRAP=0 and SAT_CLAMP=1 constants.
  - Function resize_sat(product, dout_WIDTH, mode).
  - Function mul_prod_width(w0, w1).
- Sub-module case_2_mul_pipe_stage: one valid+data register slice. It has parameter W and ports clk, reset, ce, in_v, in_d, rdy_next, v, d, rdy. It is instantiated NUM_STAGE times via generate.

Test Plan:
- Defaults, out_ready=1, inputs din0=-8192, din1=-2048 → dout=16777216. out_valid rises exactly 3 cycles after acceptance.
- dout_WIDTH=16, SAT_MODE=1:
  - 1000×100 → 32767.
  - -1000×100 → -32768.
  - 100×-3 → -300.
- dout_WIDTH=16, SAT_MODE=0, 1000×100 → 0x86A0 (-31072).
- din0_SIGNED=0, din0=16383, din1=-1 → -16383. Then din0_SIGNED=0, din1_SIGNED=0, din0=16383, din1=4095 → 67088385.
- Backpressure: stream 10 pairs (i, i+1) with out_ready low for cycles 4-9.
  - in_ready=0 after 3 outstanding.
  - All 10 products i·(i+1) are delivered in order with none lost.
  - dout is stable while stalled.
- ce low 4 cycles mid-stream → all state frozen, no transfers, output stream identical to the ce=1 run.
- Reset asserted asynchronously (mid-cycle) with 3 results in flight → out_valid=0, dout=0 and busy=0 immediately. No stale result appears after release, and the first post-reset op arrives with latency 3.
